// File: rtl/command_byte_parser.sv
// Splits a chip-select framed host byte stream into one opcode plus counted operand bytes.
// Outputs are registered one cycle after byte acceptance; bytes are never stalled, excess operands are dropped.
module command_byte_parser #(
  parameter int MAX_OPERANDS = 1024
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        transaction_active_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic [7:0]  op_code_out,
  output logic        op_code_valid_out,
  output logic [7:0]  operand_out,
  output logic        operand_valid_out,
  output logic [31:0] operand_count_out,
  output logic        overflow_out
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPCODE,
    OPERANDS,
    OVERFLOW
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_code_q, op_code_d;
  logic        op_code_vld_q, op_code_vld_d;
  logic [7:0]  operand_q, operand_d;
  logic        operand_vld_q, operand_vld_d;
  logic [31:0] count_q, count_d;
  logic        overflow_q, overflow_d;

  always_comb begin
    state_d       = state_q;
    op_code_d     = op_code_q;
    op_code_vld_d = op_code_vld_q;
    operand_d     = operand_q;
    operand_vld_d = 1'b0;
    count_d       = count_q;
    overflow_d    = overflow_q;

    case (state_q)
      IDLE: begin
        if (transaction_active_in) begin
          state_d    = WAIT_OPCODE;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      WAIT_OPCODE: begin
        if (!transaction_active_in) begin
          state_d = IDLE;
        end else if (byte_valid_in) begin
          op_code_d     = byte_in;
          op_code_vld_d = 1'b1;
          state_d       = OPERANDS;
        end
      end
      OPERANDS: begin
        if (!transaction_active_in) begin
          state_d       = IDLE;
          op_code_vld_d = 1'b0;
        end else if (byte_valid_in) begin
          // The byte that would exceed the limit is discarded, not stored.
          if (count_q == 32'(MAX_OPERANDS)) begin
            overflow_d = 1'b1;
            state_d    = OVERFLOW;
          end else begin
            operand_d     = byte_in;
            operand_vld_d = 1'b1;
            count_d       = count_q + 32'd1;
          end
        end
      end
      OVERFLOW: begin
        if (!transaction_active_in) begin
          state_d       = IDLE;
          op_code_vld_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q       <= IDLE;
      op_code_q     <= '0;
      op_code_vld_q <= 1'b0;
      operand_q     <= '0;
      operand_vld_q <= 1'b0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_code_q     <= op_code_d;
      op_code_vld_q <= op_code_vld_d;
      operand_q     <= operand_d;
      operand_vld_q <= operand_vld_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign op_code_out       = op_code_q;
  assign op_code_valid_out = op_code_vld_q;
  assign operand_out       = operand_q;
  assign operand_valid_out = operand_vld_q;
  assign operand_count_out = count_q;
  assign overflow_out      = overflow_q;

endmodule

// File: tb/tb_command_byte_parser.sv
// Directed bench: a default-limit parser and a two-operand-limit parser share one stimulus stream.
module tb_command_byte_parser;

  logic        clk;
  logic        rst_n;
  logic        active;
  logic [7:0]  byte_dat;
  logic        byte_vld;

  logic [7:0]  a_op;
  logic        a_op_vld;
  logic [7:0]  a_opnd;
  logic        a_opnd_vld;
  logic [31:0] a_cnt;
  logic        a_ovf;

  logic [7:0]  b_op;
  logic        b_op_vld;
  logic [7:0]  b_opnd;
  logic        b_opnd_vld;
  logic [31:0] b_cnt;
  logic        b_ovf;

  int checks;
  int fails;

  command_byte_parser dut_a (
    .clock_in              (clk),
    .reset_n_in            (rst_n),
    .transaction_active_in (active),
    .byte_in               (byte_dat),
    .byte_valid_in         (byte_vld),
    .op_code_out           (a_op),
    .op_code_valid_out     (a_op_vld),
    .operand_out           (a_opnd),
    .operand_valid_out     (a_opnd_vld),
    .operand_count_out     (a_cnt),
    .overflow_out          (a_ovf)
  );

  command_byte_parser #(.MAX_OPERANDS(2)) dut_b (
    .clock_in              (clk),
    .reset_n_in            (rst_n),
    .transaction_active_in (active),
    .byte_in               (byte_dat),
    .byte_valid_in         (byte_vld),
    .op_code_out           (b_op),
    .op_code_valid_out     (b_op_vld),
    .operand_out           (b_opnd),
    .operand_valid_out     (b_opnd_vld),
    .operand_count_out     (b_cnt),
    .overflow_out          (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic act, input logic vld, input logic [7:0] b);
    active   = act;
    byte_vld = vld;
    byte_dat = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    #2;
    checks++;
    if ({a_op, a_op_vld, a_opnd, a_opnd_vld, a_cnt, a_ovf} !== 50'd0) begin
      fails++;
      $display("FAIL reset_outputs: got op=%h v=%b opnd=%h pv=%b cnt=%0d ovf=%b, need all zero",
               a_op, a_op_vld, a_opnd, a_opnd_vld, a_cnt, a_ovf);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 8'h00); cyc();
    drive(1'b1, 1'b1, 8'h17); cyc();
    checks++;
    if (a_op !== 8'h17 || a_op_vld !== 1'b1 || a_opnd_vld !== 1'b0) begin
      fails++;
      $display("FAIL basic_opcode: got op=%h v=%b pv=%b, need 17 1 0", a_op, a_op_vld, a_opnd_vld);
    end
    drive(1'b1, 1'b1, 8'hAA); cyc();
    checks++;
    if (a_opnd !== 8'hAA || a_opnd_vld !== 1'b1 || a_cnt !== 32'd1) begin
      fails++;
      $display("FAIL basic_operand1: got opnd=%h pv=%b cnt=%0d, need AA 1 1", a_opnd, a_opnd_vld, a_cnt);
    end
    drive(1'b1, 1'b1, 8'hBB); cyc();
    checks++;
    if (a_opnd !== 8'hBB || a_opnd_vld !== 1'b1 || a_cnt !== 32'd2) begin
      fails++;
      $display("FAIL basic_operand2: got opnd=%h pv=%b cnt=%0d, need BB 1 2", a_opnd, a_opnd_vld, a_cnt);
    end
    drive(1'b1, 1'b0, 8'h00); cyc();
    checks++;
    if (a_opnd !== 8'hBB || a_opnd_vld !== 1'b0 || a_cnt !== 32'd2 || a_op_vld !== 1'b1) begin
      fails++;
      $display("FAIL basic_hold: got opnd=%h pv=%b cnt=%0d v=%b, need BB 0 2 1",
               a_opnd, a_opnd_vld, a_cnt, a_op_vld);
    end
    drive(1'b0, 1'b0, 8'h00); cyc();
    checks++;
    if (a_op_vld !== 1'b0 || a_op !== 8'h17 || a_opnd !== 8'hBB || a_cnt !== 32'd2) begin
      fails++;
      $display("FAIL basic_end: got v=%b op=%h opnd=%h cnt=%0d, need 0 17 BB 2",
               a_op_vld, a_op, a_opnd, a_cnt);
    end
  endtask

  task automatic test_ignore_inactive();
    drive(1'b0, 1'b1, 8'h55); cyc();
    checks++;
    if (a_op !== 8'h17 || a_op_vld !== 1'b0 || a_opnd !== 8'hBB || a_opnd_vld !== 1'b0 || a_cnt !== 32'd2) begin
      fails++;
      $display("FAIL ignore_idle: got op=%h v=%b opnd=%h pv=%b cnt=%0d, need 17 0 BB 0 2",
               a_op, a_op_vld, a_opnd, a_opnd_vld, a_cnt);
    end
    drive(1'b1, 1'b0, 8'h00); cyc();
    drive(1'b1, 1'b1, 8'h33); cyc();
    checks++;
    if (a_op !== 8'h33 || a_op_vld !== 1'b1 || a_cnt !== 32'd0) begin
      fails++;
      $display("FAIL ignore_opcode: got op=%h v=%b cnt=%0d, need 33 1 0", a_op, a_op_vld, a_cnt);
    end
    // Strobe lands in the very cycle chip-select drops.
    drive(1'b0, 1'b1, 8'h44); cyc();
    checks++;
    if (a_opnd !== 8'hBB || a_opnd_vld !== 1'b0 || a_cnt !== 32'd0 || a_op !== 8'h33 || a_op_vld !== 1'b0) begin
      fails++;
      $display("FAIL ignore_deassert: got opnd=%h pv=%b cnt=%0d op=%h v=%b, need BB 0 0 33 0",
               a_opnd, a_opnd_vld, a_cnt, a_op, a_op_vld);
    end
    drive(1'b0, 1'b0, 8'h00); cyc();
  endtask

  task automatic test_back_to_back();
    logic [7:0] opnds [3];
    opnds[0] = 8'h10;
    opnds[1] = 8'h11;
    opnds[2] = 8'h12;
    drive(1'b1, 1'b0, 8'h00); cyc();
    drive(1'b1, 1'b1, 8'h05); cyc();
    checks++;
    if (a_op !== 8'h05 || a_op_vld !== 1'b1 || a_opnd_vld !== 1'b0) begin
      fails++;
      $display("FAIL b2b_opcode: got op=%h v=%b pv=%b, need 05 1 0", a_op, a_op_vld, a_opnd_vld);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, opnds[i]); cyc();
      checks++;
      if (a_opnd !== opnds[i] || a_opnd_vld !== 1'b1 || a_cnt !== 32'(i + 1)) begin
        fails++;
        $display("FAIL b2b_operand%0d: got opnd=%h pv=%b cnt=%0d, need %h 1 %0d",
                 i, a_opnd, a_opnd_vld, a_cnt, opnds[i], i + 1);
      end
    end
    drive(1'b0, 1'b0, 8'h00); cyc();
  endtask

  task automatic test_overflow();
    logic [7:0] opnds [3];
    opnds[0] = 8'h01;
    opnds[1] = 8'h02;
    opnds[2] = 8'h03;
    drive(1'b1, 1'b0, 8'h00); cyc();
    checks++;
    if (b_ovf !== 1'b0 || b_cnt !== 32'd0) begin
      fails++;
      $display("FAIL ovf_clear_from_prev: got ovf=%b cnt=%0d, need 0 0", b_ovf, b_cnt);
    end
    drive(1'b1, 1'b1, 8'h20); cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, opnds[i]); cyc();
      checks++;
      if (b_opnd !== opnds[i] || b_opnd_vld !== 1'b1 || b_cnt !== 32'(i + 1) || b_ovf !== 1'b0) begin
        fails++;
        $display("FAIL ovf_operand%0d: got opnd=%h pv=%b cnt=%0d ovf=%b, need %h 1 %0d 0",
                 i, b_opnd, b_opnd_vld, b_cnt, b_ovf, opnds[i], i + 1);
      end
    end
    drive(1'b1, 1'b1, opnds[2]); cyc();
    checks++;
    if (b_opnd !== 8'h02 || b_opnd_vld !== 1'b0 || b_cnt !== 32'd2 || b_ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drop: got opnd=%h pv=%b cnt=%0d ovf=%b, need 02 0 2 1",
               b_opnd, b_opnd_vld, b_cnt, b_ovf);
    end
    checks++;
    if (a_cnt !== 32'd3 || a_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_default_limit: got cnt=%0d ovf=%b, need 3 0", a_cnt, a_ovf);
    end
    drive(1'b1, 1'b1, 8'h04); cyc();
    drive(1'b0, 1'b0, 8'h00); cyc();
    checks++;
    if (b_ovf !== 1'b1 || b_cnt !== 32'd2 || b_op_vld !== 1'b0 || b_opnd_vld !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d v=%b pv=%b, need 1 2 0 0",
               b_ovf, b_cnt, b_op_vld, b_opnd_vld);
    end
    drive(1'b1, 1'b0, 8'h00); cyc();
    checks++;
    if (b_ovf !== 1'b0 || b_cnt !== 32'd0) begin
      fails++;
      $display("FAIL ovf_next_clear: got ovf=%b cnt=%0d, need 0 0", b_ovf, b_cnt);
    end
    drive(1'b0, 1'b0, 8'h00); cyc();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'h00); cyc();
    drive(1'b1, 1'b1, 8'h60); cyc();
    drive(1'b1, 1'b1, 8'h61); cyc();
    drive(1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_op, a_op_vld, a_opnd, a_opnd_vld, a_cnt, a_ovf} !== 50'd0) begin
      fails++;
      $display("FAIL reset_mid_async: got op=%h v=%b opnd=%h pv=%b cnt=%0d ovf=%b, need all zero",
               a_op, a_op_vld, a_opnd, a_opnd_vld, a_cnt, a_ovf);
    end
    cyc();
    #2;
    rst_n = 1'b1;
    cyc();
    drive(1'b1, 1'b1, 8'h62); cyc();
    checks++;
    if (a_op !== 8'h62 || a_op_vld !== 1'b1 || a_opnd_vld !== 1'b0 || a_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_fresh: got op=%h v=%b pv=%b cnt=%0d, need 62 1 0 0",
               a_op, a_op_vld, a_opnd_vld, a_cnt);
    end
    drive(1'b0, 1'b0, 8'h00); cyc();
  endtask

  task automatic test_empty();
    int rises;
    int pulses;
    rises  = 0;
    pulses = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (a_op_vld) rises++;
      if (a_opnd_vld) pulses++;
    end
    drive(1'b0, 1'b0, 8'h00); cyc();
    if (a_op_vld) rises++;
    checks++;
    if (rises !== 0 || pulses !== 0 || a_cnt !== 32'd0 || a_op !== 8'h62) begin
      fails++;
      $display("FAIL empty_txn: got vld_cycles=%0d pulses=%0d cnt=%0d op=%h, need 0 0 0 62",
               rises, pulses, a_cnt, a_op);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_ignore_inactive();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/command_byte_parser.md
COMMAND_BYTE_PARSER -- requirements
Module: command_byte_parser

Interface
REQ-001 The block SHALL have parameter MAX_OPERANDS, default 1024, the maximum operands accepted per transaction.
REQ-002 The block SHALL have port clock_in, input, 1, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset_n_in, input, 1, reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port transaction_active_in, input, 1, high while the host holds chip-select (already synchronous to clock_in).
REQ-005 The block SHALL have port byte_in, input, 8, received host byte.
REQ-006 The block SHALL have port byte_valid_in, input, 1, one-cycle strobe qualifying byte_in.
REQ-007 The block SHALL have port op_code_out, output, 8, opcode of the current transaction.
REQ-008 The block SHALL have port op_code_valid_out, output, 1, level; high from opcode capture until the transaction ends.
REQ-009 The block SHALL have port operand_out, output, 8, latest operand byte.
REQ-010 The block SHALL have port operand_valid_out, output, 1, one-cycle pulse qualifying operand_out.
REQ-011 The block SHALL have port operand_count_out, output, 32 (integer), number of operands received so far in this transaction.
REQ-012 The block SHALL have port overflow_out, output, 1, sticky flag set when a byte beyond MAX_OPERANDS is received.

Function
REQ-013 The block SHALL implement states IDLE, WAIT_OPCODE, OPERANDS, OVERFLOW.
REQ-014 IDLE -> WAIT_OPCODE SHALL occur on the first cycle transaction_active_in is high; operand_count_out and overflow_out SHALL clear to 0 on that transition.
REQ-015 In WAIT_OPCODE, a byte accepted (byte_valid_in and transaction_active_in both high) SHALL be registered into op_code_out, with op_code_valid_out high the next cycle, state -> OPERANDS.
REQ-016 In OPERANDS, each accepted byte SHALL appear on operand_out with operand_valid_out high for exactly one cycle, one cycle after acceptance, and operand_count_out incremented by 1 in that same cycle (first operand -> count 1).
REQ-017 operand_out and operand_count_out SHALL hold their values between pulses.
REQ-018 An accepted byte arriving when operand_count_out equals MAX_OPERANDS SHALL be dropped (no pulse, no count change), overflow_out SHALL set the next cycle, and state -> OVERFLOW.
REQ-019 In OVERFLOW, all bytes SHALL be dropped; overflow_out SHALL remain high until the next IDLE -> WAIT_OPCODE transition.
REQ-020 From any non-IDLE state, transaction_active_in low SHALL return to IDLE the next cycle, dropping op_code_valid_out to 0 then; op_code_out, operand_out and operand_count_out SHALL hold.
REQ-021 A byte with byte_valid_in high while transaction_active_in is low SHALL be ignored in every state, including the cycle transaction_active_in deasserts.
REQ-022 Transactions that end in WAIT_OPCODE SHALL produce no output change besides the count/overflow clear.
REQ-023 Back-to-back strobes on consecutive cycles SHALL all be processed; no backpressure exists.
REQ-024 A new transaction SHALL require at least one cycle of transaction_active_in low; op_code_valid_out SHALL be low for at least that cycle.

Reset
REQ-025 While reset_n_in is low, state SHALL be IDLE and all outputs 0 (op_code_out 0x00, op_code_valid_out 0, operand_out 0x00, operand_valid_out 0, operand_count_out 0, overflow_out 0), asynchronously.
REQ-026 Reset asserted mid-transaction SHALL abort it; after release, a transaction still active SHALL be treated as a fresh transaction starting in WAIT_OPCODE.

Verification
REQ-027 Active high, bytes 0x17 then 0xAA,0xBB -> op_code_out 0x17, valid high; operand pulses 0xAA count 1, 0xBB count 2; active low -> op_code_valid_out 0 next cycle.
REQ-028 MAX_OPERANDS=2, opcode 0x20 + operands 0x01,0x02,0x03 -> two pulses, count stays 2, overflow_out 1; next transaction clears overflow_out and count.
REQ-029 byte_valid_in strobed with transaction_active_in low, then in the deassert cycle -> no output change at all.
REQ-030 Four consecutive-cycle strobes (0x05,0x10,0x11,0x12) -> opcode 0x05, three consecutive operand pulses, count 1,2,3.
REQ-031 reset_n_in pulled low between operand 1 and 2 -> all outputs 0 immediately; after release with transaction still active, next byte is captured as opcode.
REQ-032 Transaction opened and closed with no bytes -> op_code_valid_out never rises, no pulses, count 0.
